// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and key codes for the UART receiver and snake core
package snake_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    localparam logic [7:0] KEY_UP    = 8'd65;
    localparam logic [7:0] KEY_DOWN  = 8'd66;
    localparam logic [7:0] KEY_RIGHT = 8'd67;
    localparam logic [7:0] KEY_LEFT  = 8'd68;

    function automatic logic is_dir_key(input logic [7:0] c);
        return (c >= KEY_UP) && (c <= KEY_LEFT);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line in, received byte and strobes out
interface uart_rx_if;
    logic       rx;
    logic [7:0] dataRX;
    logic       WR_RX;
    logic       frame_err;

    modport master (
        input  rx,
        output dataRX,
        output WR_RX,
        output frame_err
    );

    modport slave (
        output rx,
        input  dataRX,
        input  WR_RX,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// rtl/uart_rx_sync_2ff.sv - generic two-flop synchronizer with configurable reset value
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and break handling
module uart_rx
    import snake_pkg::*;
#(
    parameter int CLKS_PER_BIT = 273,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic px_clk,
    input  logic rst,
    uart_rx_if.master bus
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s;
    uart_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             wr_q;
    logic             ferr_q;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i (px_clk),
        .rst_i (rst),
        .d_i   (bus.rx),
        .q_o   (rx_s)
    );

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        // Line is LSB first, so each new bit enters at the top.
                        shift_q   <= {rx_s, shift_q[7:1]};
                        cnt_q     <= '0;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            wr_q    <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.dataRX    = data_q;
    assign bus.WR_RX     = wr_q;
    assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int CLK_T   = 10000;
    localparam int BIT_NOM = CPB * CLK_T;
    localparam int BIT_SLO = BIT_NOM * 103 / 100;
    localparam int BIT_FST = BIT_NOM * 97 / 100;

    logic clk;
    logic rst;
    int   cyc;

    uart_rx_if u_if ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .HALF_BIT     (CPB / 2)
    ) dut (
        .px_clk (clk),
        .rst    (rst),
        .bus    (u_if)
    );

    initial clk = 1'b0;
    always #(CLK_T / 2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed behaviour, sampled on the falling edge.
    logic [7:0] got_q[$];
    int         wr_time[$];
    int         wr_cnt;
    int         ferr_cnt;
    int         both_hi;
    int         wide;
    logic       wr_prev;
    logic       ferr_prev;

    always @(negedge clk) begin
        if (u_if.WR_RX) begin
            wr_cnt++;
            got_q.push_back(u_if.dataRX);
            wr_time.push_back(cyc);
        end
        if (u_if.frame_err) ferr_cnt++;
        if (u_if.WR_RX && u_if.frame_err) both_hi++;
        if ((u_if.WR_RX && wr_prev) || (u_if.frame_err && ferr_prev)) wide++;
        wr_prev   = u_if.WR_RX;
        ferr_prev = u_if.frame_err;
    end

    // Reference model: bytes the line should deliver, in order.
    logic [7:0] exp_q[$];
    int         exp_wr;
    int         exp_ferr;
    logic [7:0] exp_data;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_v);
        logic [9:0] f;
        f = {stop_v, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            u_if.rx = f[i];
            #(per);
        end
        u_if.rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b, input int per);
        send_frame(b, per, 1'b1);
        exp_q.push_back(b);
        exp_wr++;
        exp_data = b;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_step(input string tag);
        logic [7:0] e;
        logic [7:0] g;
        chk({tag, "_wr_count"}, wr_cnt, exp_wr);
        chk({tag, "_ferr_count"}, ferr_cnt, exp_ferr);
        chk({tag, "_dataRX"}, u_if.dataRX, exp_data);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk({tag, "_byte"}, g, e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] f41;
        int         per;
        int         gap;

        checks   = 0;
        errors   = 0;
        wr_cnt   = 0;
        ferr_cnt = 0;
        both_hi  = 0;
        wide     = 0;
        wr_prev  = 1'b0;
        ferr_prev = 1'b0;
        exp_wr   = 0;
        exp_ferr = 0;
        exp_data = 8'h00;
        cyc      = 0;
        u_if.rx  = 1'b1;
        rst      = 1'b1;

        settle(3);
        chk("reset_dataRX", u_if.dataRX, 8'h00);
        chk("reset_WR_RX", u_if.WR_RX, 1'b0);
        chk("reset_frame_err", u_if.frame_err, 1'b0);
        rst = 1'b0;
        settle(20);

        send_good(8'h41, BIT_NOM);
        settle(40);
        check_step("single_41");

        settle(1);
        send_good(8'h42, BIT_NOM);
        send_good(8'h44, BIT_NOM);
        settle(40);
        chk("b2b_spacing", wr_time[wr_time.size()-1] - wr_time[wr_time.size()-2], 160);
        check_step("b2b_42_44");

        u_if.rx = 1'b0;
        #(4 * CLK_T);
        u_if.rx = 1'b1;
        settle(40);
        check_step("glitch");
        send_good(8'h43, BIT_NOM);
        settle(40);
        check_step("after_glitch_43");

        send_frame(8'h41, BIT_NOM, 1'b0);
        u_if.rx = 1'b0;
        exp_ferr++;
        #(40 * BIT_NOM);
        check_step("break_held");
        u_if.rx = 1'b1;
        settle(2 * CPB);
        send_good(8'h44, BIT_NOM);
        settle(40);
        check_step("after_break_44");

        // Abort 0x41 partway through data bit 4 with a reset.
        f41 = 8'h41;
        u_if.rx = 1'b0;
        #(BIT_NOM);
        for (int i = 0; i < 4; i++) begin
            u_if.rx = f41[i];
            #(BIT_NOM);
        end
        u_if.rx = f41[4];
        #(BIT_NOM / 2);
        rst = 1'b1;
        #(CLK_T / 10);
        chk("midreset_dataRX", u_if.dataRX, 8'h00);
        chk("midreset_WR_RX", u_if.WR_RX, 1'b0);
        exp_data = 8'h00;
        #(3 * CLK_T);
        u_if.rx = 1'b1;
        rst = 1'b0;
        settle(3 * CPB);
        check_step("midreset");
        send_good(8'h42, BIT_NOM);
        settle(40);
        check_step("after_reset_42");

        send_good(8'h55, BIT_FST);
        #(BIT_NOM);
        send_good(8'hAA, BIT_SLO);
        settle(40);
        check_step("baud_tol");

        for (int n = 0; n < 12; n++) begin
            b   = 8'($urandom_range(0, 255));
            per = BIT_FST + 400 * int'($urandom_range(0, (BIT_SLO - BIT_FST) / 400));
            gap = int'($urandom_range(0, 2));
            send_good(b, per);
            if (gap > 0) #(gap * BIT_NOM);
        end
        settle(40);
        check_step("random");

        chk("never_both_high", both_hi, 0);
        chk("single_cycle_pulses", wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
